// File: rtl/tc_timer_if.sv
// Bus-side signals of the memory-mapped countdown timer: word access plus interrupt line.
interface tc_timer_if;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, byteen, wdata, input rdata, irq);
    modport slave  (input addr, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/tc_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload,
// registered interrupt output gated by the IM mask bit.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for EN
//   LOAD   | copy PRESET into COUNT
//   CNT    | decrementing; expiry at COUNT <= 1 raises irq_flag
//   INT    | expiry cycle; one-shot clears EN, auto-reload reloads
module tc_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
    input  logic       clk,
    input  logic       reset,
    tc_timer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;
    logic        irq_q;

    logic [31:0] word_addr;
    logic        hit_ctrl, hit_preset, hit_count, wr;

    assign word_addr  = bus.addr & 32'hffff_fffc;
    assign hit_ctrl   = (word_addr == BASE_ADDR);
    assign hit_preset = (word_addr == BASE_ADDR + 32'd4);
    assign hit_count  = (word_addr == BASE_ADDR + 32'd8);
    assign wr         = |bus.byteen;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq_q    <= flag_d & im_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        unique case (state_q)
            S_IDLE: if (en_q) state_d = S_LOAD;
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    flag_d  = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (mode_q == 2'b01) begin
                    flag_d  = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes come last so they override any same-cycle FSM update.
        if (wr && hit_ctrl) begin
            flag_d = 1'b0;
            if (bus.byteen[0]) begin
                en_d   = bus.wdata[0];
                mode_d = bus.wdata[2:1];
                im_d   = bus.wdata[3];
            end
        end
        if (wr && hit_preset) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.byteen[k]) preset_d[8*k +: 8] = bus.wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (hit_ctrl)        bus.rdata = {28'd0, im_q, mode_q, en_q};
        else if (hit_preset) bus.rdata = preset_q;
        else if (hit_count)  bus.rdata = count_q;
    end

    assign bus.irq = irq_q;
endmodule

// File: tb/tb_tc_timer.sv
// Self-checking bench for tc_timer: register-access vector table plus cycle-exact
// sequences whose expected COUNT/irq values go through a scoreboard queue.
module tb_tc_timer;
    localparam logic [31:0] A_CTRL = 32'h0000_7f00;
    localparam logic [31:0] A_PRE  = 32'h0000_7f04;
    localparam logic [31:0] A_CNT  = 32'h0000_7f08;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
        bit          chk;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] rd;
    } vec_t;

    logic clk;
    logic reset;
    tc_timer_if bus_if ();

    tc_timer #(.BASE_ADDR(32'h0000_7f00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    exp_t sb_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[14];

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Scoreboard: one entry per driven cycle, compared just after the edge it describes.
    always @(posedge clk) begin
        #3;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.chk) begin
                n_tests++;
                if (bus_if.rdata !== e.rd || bus_if.irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s: rdata=%h irq=%b, required rdata=%h irq=%b",
                             e.name, bus_if.rdata, bus_if.irq, e.rd, e.irq);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic cycle(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                         input string nm, input logic [31:0] rd, input logic irq, input bit chk);
        bus_if.addr   = a;
        bus_if.byteen = be;
        bus_if.wdata  = d;
        sb_q.push_back('{nm, rd, irq, chk});
        @(negedge clk);
        bus_if.byteen = 4'h0;
        bus_if.addr   = A_CNT;
    endtask

    task automatic idle(input string nm, input logic [31:0] cnt, input logic irq);
        cycle(A_CNT, 4'h0, 32'h0, nm, cnt, irq, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #4;
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Reset pulse between edges; state must clear with no clock edge.
    task automatic mid_reset_check(input string nm);
        #2;
        reset = 1'b1;
        #1;
        bus_if.addr = A_CNT;
        #1;
        check({nm, "_count"}, bus_if.rdata, 32'h0);
        check({nm, "_irq"}, {31'd0, bus_if.irq}, 32'h0);
        bus_if.addr = A_CTRL;
        #1;
        check({nm, "_ctrl"}, bus_if.rdata, 32'h0);
        bus_if.addr = A_PRE;
        #1;
        check({nm, "_preset"}, bus_if.rdata, 32'h0);
        reset = 1'b0;
        bus_if.addr = A_CNT;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus_if.addr   = A_CNT;
        bus_if.byteen = 4'h0;
        bus_if.wdata  = 32'h0;

        vecs[0]  = '{A_CTRL,      4'h0, 32'h0,         32'h0};
        vecs[1]  = '{A_PRE,       4'h0, 32'h0,         32'h0};
        vecs[2]  = '{A_CNT,       4'h0, 32'h0,         32'h0};
        vecs[3]  = '{A_PRE,       4'hf, 32'h1234_5678, 32'h1234_5678};
        vecs[4]  = '{A_PRE,       4'h4, 32'h00ab_0000, 32'h12ab_5678};
        vecs[5]  = '{A_PRE,       4'h1, 32'hffff_ffcc, 32'h12ab_56cc};
        vecs[6]  = '{A_CTRL,      4'hf, 32'hffff_fff6, 32'h0000_0006};
        vecs[7]  = '{A_CTRL,      4'h2, 32'h0000_000f, 32'h0000_0006};
        vecs[8]  = '{A_CNT,       4'hf, 32'h0000_ffff, 32'h0};
        vecs[9]  = '{32'h7f0c,    4'hf, 32'hdead_beef, 32'h0};
        vecs[10] = '{32'h7f03,    4'h0, 32'h0,         32'h0000_0006};
        vecs[11] = '{32'h8f00,    4'h0, 32'h0,         32'h0};
        vecs[12] = '{A_PRE,       4'h0, 32'h0,         32'h12ab_56cc};
        vecs[13] = '{A_CTRL,      4'hf, 32'h0,         32'h0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            cycle(vecs[i].a, vecs[i].be, vecs[i].d, $sformatf("vec%0d", i), vecs[i].rd, 1'b0, 1'b1);

        // Reset in the middle of a count.
        do_reset();
        cycle(A_PRE, 4'hf, 32'd100, "t1_pre", 32'd100, 1'b0, 1'b1);
        cycle(A_CTRL, 4'hf, 32'h9, "t1_ctrl", 32'h9, 1'b0, 1'b1);
        idle("t1_load", 32'd0, 1'b0);
        idle("t1_c100", 32'd100, 1'b0);
        idle("t1_c99", 32'd99, 1'b0);
        mid_reset_check("t1_rst");
        idle("t1_after", 32'd0, 1'b0);

        // One-shot, PRESET=5.
        do_reset();
        cycle(A_PRE, 4'hf, 32'd5, "t2_pre", 32'd5, 1'b0, 1'b1);
        cycle(A_CTRL, 4'hf, 32'h9, "t2_ctrl", 32'h9, 1'b0, 1'b1);
        idle("t2_load", 32'd0, 1'b0);
        for (int v = 5; v >= 1; v--) idle($sformatf("t2_c%0d", v), v, 1'b0);
        idle("t2_expire", 32'd0, 1'b1);
        idle("t2_hold", 32'd0, 1'b1);
        cycle(A_CTRL, 4'h0, 32'h0, "t2_en_cleared", 32'h8, 1'b1, 1'b1);
        cycle(A_CTRL, 4'hf, 32'h0, "t2_ack", 32'h0, 1'b0, 1'b1);
        idle("t2_quiet", 32'd0, 1'b0);

        // PRESET=0 expires after one CNT cycle; then reset with irq pending.
        do_reset();
        cycle(A_PRE, 4'hf, 32'd0, "t0_pre", 32'd0, 1'b0, 1'b1);
        cycle(A_CTRL, 4'hf, 32'h9, "t0_ctrl", 32'h9, 1'b0, 1'b1);
        idle("t0_load", 32'd0, 1'b0);
        idle("t0_cnt", 32'd0, 1'b0);
        idle("t0_expire", 32'd0, 1'b1);
        idle("t0_hold", 32'd0, 1'b1);
        mid_reset_check("t0_rst");

        // Auto-reload, PRESET=3: period of 5 cycles, irq pulse one cycle.
        do_reset();
        cycle(A_PRE, 4'hf, 32'd3, "t3_pre", 32'd3, 1'b0, 1'b1);
        cycle(A_CTRL, 4'hf, 32'hb, "t3_ctrl", 32'hb, 1'b0, 1'b1);
        idle("t3_first_load", 32'd0, 1'b0);
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 5; k++)
                idle($sformatf("t3_p%0d_k%0d", p, k), (k <= 3) ? 32'(3 - k) : 32'd0, k == 3);
        cycle(A_CTRL, 4'hf, 32'h0, "t3_stop", 32'h0, 1'b0, 1'b1);

        // Masked irq and byte-lane PRESET write.
        do_reset();
        cycle(A_PRE, 4'hf, 32'd2, "t4_pre", 32'd2, 1'b0, 1'b1);
        cycle(A_CTRL, 4'hf, 32'h1, "t4_ctrl", 32'h1, 1'b0, 1'b1);
        idle("t4_load", 32'd0, 1'b0);
        idle("t4_c2", 32'd2, 1'b0);
        idle("t4_c1", 32'd1, 1'b0);
        idle("t4_expire_masked", 32'd0, 1'b0);
        idle("t4_hold_masked", 32'd0, 1'b0);
        cycle(A_CTRL, 4'h0, 32'h0, "t4_en_cleared", 32'h0, 1'b0, 1'b1);
        cycle(A_PRE, 4'h4, 32'h00ab_0000, "t4_lane2", 32'h00ab_0002, 1'b0, 1'b1);

        // CTRL=0 written on the same edge COUNT goes 1->0.
        do_reset();
        cycle(A_PRE, 4'hf, 32'd3, "t5_pre", 32'd3, 1'b0, 1'b1);
        cycle(A_CTRL, 4'hf, 32'h9, "t5_ctrl", 32'h9, 1'b0, 1'b1);
        idle("t5_load", 32'd0, 1'b0);
        idle("t5_c3", 32'd3, 1'b0);
        idle("t5_c2", 32'd2, 1'b0);
        idle("t5_c1", 32'd1, 1'b0);
        cycle(A_CTRL, 4'hf, 32'h0, "t5_collide", 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) idle($sformatf("t5_idle%0d", k), 32'd0, 1'b0);
        cycle(A_CNT, 4'hf, 32'h0000_ffff, "t5_count_ro", 32'd0, 1'b0, 1'b1);

        // PRESET rewritten mid-count, auto-reload picks it up next period.
        do_reset();
        cycle(A_PRE, 4'hf, 32'd10, "t6_pre", 32'd10, 1'b0, 1'b1);
        cycle(A_CTRL, 4'hf, 32'hb, "t6_ctrl", 32'hb, 1'b0, 1'b1);
        idle("t6_load", 32'd0, 1'b0);
        for (int v = 10; v >= 7; v--) idle($sformatf("t6_c%0d", v), v, 1'b0);
        cycle(A_PRE, 4'hf, 32'd2, "t6_pre_mid", 32'd2, 1'b0, 1'b1);
        cycle(A_CNT, 4'h0, 32'h0, "t6_c5", 32'd5, 1'b0, 1'b1);
        for (int v = 4; v >= 1; v--) idle($sformatf("t6_c%0d", v), v, 1'b0);
        idle("t6_expire", 32'd0, 1'b1);
        idle("t6_reload", 32'd0, 1'b0);
        idle("t6_n2", 32'd2, 1'b0);
        idle("t6_n1", 32'd1, 1'b0);
        idle("t6_n_expire", 32'd0, 1'b1);
        idle("t6_n_reload", 32'd0, 1'b0);
        cycle(A_CTRL, 4'hf, 32'h0, "t6_stop", 32'h0, 1'b0, 1'b1);

        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
